// File: rtl/regfile_sb_pkg.sv
// Shared constants and sizing helpers for the scoreboarded register file.
package regfile_sb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  // Architectural zero register index and its constant read value bit
  localparam int unsigned ZERO_REG = 0;
  localparam logic        ZERO     = 1'b0;

  localparam logic READ_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  // Width of the busy vector: one bit per architectural register
  function automatic int unsigned busy_w(input int unsigned addr_w);
    return 32'(1) << addr_w;
  endfunction

  // Width of the busy counter: wide enough to hold NUM_REGS
  function automatic int unsigned busy_cnt_w(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking for in-flight producers, with a running popcount.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic                issue_i,
  input  logic [ADDR_W-1:0]   issue_addr_i,
  input  logic                flush_i,
  output logic [2**ADDR_W-1:0] busy_o,
  output logic [ADDR_W:0]     busy_cnt_o
);

  localparam int unsigned NUM_REGS = busy_w(ADDR_W);
  localparam int unsigned CNT_W    = busy_cnt_w(ADDR_W);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                set_hit;
  logic                clr_hit;
  logic                cnt_inc;
  logic                cnt_dec;

  // Next busy vector and incremental count; set beats clear, flush beats both
  always_comb begin
    set_hit  = (issue_i == 1'b1) && (issue_addr_i != ADDR_W'(ZERO_REG));
    clr_hit  = (we_i == WRITE_ENABLE) && (waddr_i != ADDR_W'(ZERO_REG));
    cnt_inc  = set_hit && !busy_q[issue_addr_i];
    cnt_dec  = clr_hit && busy_q[waddr_i] && !(set_hit && (issue_addr_i == waddr_i));
    busy_nxt = busy_q;
    if (clr_hit) begin
      busy_nxt[waddr_i] = 1'b0;
    end
    if (set_hit) begin
      busy_nxt[issue_addr_i] = 1'b1;
    end
    cnt_nxt = cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    if (flush_i) begin
      busy_nxt = '0;
      cnt_nxt  = '0;
    end
  end

  // Busy state and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with hardwired x0, optional write bypass and a RAW scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_RD-1:0]          re_i,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr_i,
  output logic [NUM_RD*DATA_W-1:0]   rdata_o,
  output logic [NUM_RD-1:0]          rvalid_o,
  input  logic                       we_i,
  input  logic [ADDR_W-1:0]          waddr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       issue_i,
  input  logic [ADDR_W-1:0]          issue_addr_i,
  input  logic                       flush_i,
  output logic [ADDR_W:0]            busy_cnt_o
);

  localparam int unsigned NUM_REGS = busy_w(ADDR_W);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_hit;

  assign wr_hit = (we_i == WRITE_ENABLE) && (waddr_i != ADDR_W'(ZERO_REG));

  // Storage array; x0 is never written so it stays at its reset value
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_hit) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .we_i         (we_i),
    .waddr_i      (waddr_i),
    .issue_i      (issue_i),
    .issue_addr_i (issue_addr_i),
    .flush_i      (flush_i),
    .busy_o       (busy),
    .busy_cnt_o   (busy_cnt_o)
  );

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    assign ra = raddr_i[k*ADDR_W +: ADDR_W];

    // Read mux: x0, disabled port, same-cycle bypass, then array plus scoreboard
    always_comb begin
      rd_data  = {DATA_W{ZERO}};
      rd_valid = 1'b0;
      if (ra == ADDR_W'(ZERO_REG)) begin
        rd_valid = re_i[k];
      end else if (re_i[k] == READ_ENABLE) begin
        if ((BYPASS != 0) && wr_hit && (waddr_i == ra)) begin
          rd_data  = wdata_i;
          rd_valid = 1'b1;
        end else begin
          rd_data  = regs_q[ra];
          rd_valid = !busy[ra];
        end
      end
    end

    assign rdata_o[k*DATA_W +: DATA_W] = rd_data;
    assign rvalid_o[k]                 = rd_valid;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a 2-port bypassing build and a 3-port non-bypassing build
// share write/issue/flush stimulus and are checked against an array-based model.
module tb_regfile_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [2:0]    re;
  logic [AW-1:0] ra [3];
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic          iss;
  logic [AW-1:0] ia;
  logic          fl;

  logic [2*AW-1:0] raddr_a;
  logic [3*AW-1:0] raddr_b;
  assign raddr_a = {ra[1], ra[0]};
  assign raddr_b = {ra[2], ra[1], ra[0]};

  logic [2*DW-1:0] rdata_a;
  logic [1:0]      rvalid_a;
  logic [AW:0]     cnt_a;
  logic [3*DW-1:0] rdata_b;
  logic [2:0]      rvalid_b;
  logic [AW:0]     cnt_b;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .BYPASS(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .re_i(re[1:0]), .raddr_i(raddr_a),
    .rdata_o(rdata_a), .rvalid_o(rvalid_a), .we_i(we), .waddr_i(wa),
    .wdata_i(wd), .issue_i(iss), .issue_addr_i(ia), .flush_i(fl),
    .busy_cnt_o(cnt_a)
  );

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(3), .BYPASS(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .re_i(re), .raddr_i(raddr_b),
    .rdata_o(rdata_b), .rvalid_o(rvalid_b), .we_i(we), .waddr_i(wa),
    .wdata_i(wd), .issue_i(iss), .issue_addr_i(ia), .flush_i(fl),
    .busy_cnt_o(cnt_b)
  );

  // Architectural model: register contents and the set of registers awaiting a producer
  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];
  bit            chk_en = 1'b0;
  int            n_cmp  = 0;
  int            n_err  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < int'(NR); i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic m_read(input logic r, input logic [AW-1:0] a, input bit byp,
                        output logic [DW-1:0] d, output logic v);
    d = '0;
    v = 1'b0;
    if (a == '0) v = r;
    else if (r) begin
      if (byp && we && wa == a) begin
        d = wd;
        v = 1'b1;
      end else begin
        d = m_regs[a];
        v = !m_busy[a];
      end
    end
  endtask

  // Per-cycle comparison of every output of both builds against the model
  task automatic sample();
    logic [DW-1:0] d;
    logic          v;
    @(negedge clk);
    #1;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        m_read(re[k], ra[k], 1'b1, d, v);
        chk($sformatf("A.rdata%0d", k), 64'(rdata_a[k*DW +: DW]), 64'(d));
        chk($sformatf("A.rvalid%0d", k), 64'(rvalid_a[k]), 64'(v));
      end
      for (int k = 0; k < 3; k++) begin
        m_read(re[k], ra[k], 1'b0, d, v);
        chk($sformatf("B.rdata%0d", k), 64'(rdata_b[k*DW +: DW]), 64'(d));
        chk($sformatf("B.rvalid%0d", k), 64'(rvalid_b[k]), 64'(v));
      end
      chk("A.busy_cnt", 64'(cnt_a), 64'(m_cnt()));
      chk("B.busy_cnt", 64'(cnt_b), 64'(m_cnt()));
    end
  endtask

  // Advance the model across a clock edge using the inputs held during the cycle
  task automatic edge_upd();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < int'(NR); i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
      chk_en = 1'b1;
    end else begin
      if (we && wa != '0) m_regs[wa] = wd;
      if (fl) begin
        for (int i = 0; i < int'(NR); i++) m_busy[i] = 1'b0;
      end else begin
        if (we && wa != '0) m_busy[wa] = 1'b0;
        if (iss && ia != '0) m_busy[ia] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic cyc();
    sample();
    edge_upd();
  endtask

  task automatic idle();
    rst = 1'b0; re = '0; we = 1'b0; wa = '0; wd = '0;
    iss = 1'b0; ia = '0; fl = 1'b0;
    for (int k = 0; k < 3; k++) ra[k] = '0;
  endtask

  task automatic rd(input int p, input int a);
    re[p] = 1'b1;
    ra[p] = AW'(a);
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    we = 1'b1;
    wa = AW'(a);
    wd = d;
  endtask

  task automatic issue(input int a);
    iss = 1'b1;
    ia  = AW'(a);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    cyc();
    cyc();

    // Reset state: reads return zero and are valid
    idle(); rd(0, 5); rd(1, 0); sample();
    chk("rst_rdata0", 64'(rdata_a[31:0]), 64'h0);
    chk("rst_rdata1", 64'(rdata_a[63:32]), 64'h0);
    chk("rst_rvalid", 64'(rvalid_a), 64'h3);
    chk("rst_cnt", 64'(cnt_a), 64'h0);
    edge_upd();

    // Writes to x0 are discarded
    idle(); wr(0, 32'hDEAD); cyc();
    idle(); rd(0, 0); sample();
    chk("x0_rdata", 64'(rdata_a[31:0]), 64'h0);
    chk("x0_rvalid", 64'(rvalid_a[0]), 64'h1);
    edge_upd();

    // Issue x7 makes it busy
    idle(); issue(7); cyc();
    idle(); rd(0, 7); sample();
    chk("x7_busy_rvalid", 64'(rvalid_a[0]), 64'h0);
    chk("x7_busy_cnt", 64'(cnt_a), 64'h1);
    chk("x7_busy_model", 64'(m_cnt()), 64'h1);
    edge_upd();

    // Writeback of x7: bypass build forwards, non-bypass build sees old state
    idle(); wr(7, 32'h1234); rd(0, 7); sample();
    chk("x7_byp_rdata", 64'(rdata_a[31:0]), 64'h1234);
    chk("x7_byp_rvalid", 64'(rvalid_a[0]), 64'h1);
    chk("x7_nobyp_rdata", 64'(rdata_b[31:0]), 64'h0);
    chk("x7_nobyp_rvalid", 64'(rvalid_b[0]), 64'h0);
    edge_upd();
    idle(); rd(0, 7); sample();
    chk("x7_wb_cnt", 64'(cnt_a), 64'h0);
    chk("x7_wb_rdata_b", 64'(rdata_b[31:0]), 64'h1234);
    chk("x7_wb_rvalid_b", 64'(rvalid_b[0]), 64'h1);
    edge_upd();

    // Non-bypass read of the register being written returns the old value
    idle(); wr(3, 32'h11); cyc();
    idle(); wr(3, 32'h22); rd(0, 3); sample();
    chk("x3_nobyp_old", 64'(rdata_b[31:0]), 64'h11);
    chk("x3_byp_new", 64'(rdata_a[31:0]), 64'h22);
    edge_upd();
    idle(); rd(0, 3); sample();
    chk("x3_nobyp_next", 64'(rdata_b[31:0]), 64'h22);
    edge_upd();

    // Issue and write to the same busy register: set wins, data still written
    idle(); issue(9); cyc();
    idle(); issue(9); wr(9, 32'h55); sample();
    chk("x9_pre_cnt", 64'(cnt_a), 64'h1);
    edge_upd();
    idle(); rd(0, 9); sample();
    chk("x9_same_cnt", 64'(cnt_a), 64'h1);
    chk("x9_same_rdata", 64'(rdata_a[31:0]), 64'h55);
    chk("x9_same_rvalid", 64'(rvalid_a[0]), 64'h0);
    edge_upd();

    // Issue x4 while clearing x9: count unchanged
    idle(); issue(4); wr(9, 32'h66); cyc();
    idle(); rd(0, 9); rd(1, 4); sample();
    chk("swap_cnt", 64'(cnt_a), 64'h1);
    chk("swap_rvalid", 64'(rvalid_a), 64'h1);
    chk("swap_rdata", 64'(rdata_a[31:0]), 64'h66);
    edge_upd();

    // Consecutive issues then a flush that overrides a same-cycle issue
    idle(); fl = 1'b1; cyc();
    idle(); issue(1); cyc();
    idle(); issue(2); cyc();
    idle(); issue(3); cyc();
    idle(); sample();
    chk("three_cnt", 64'(cnt_a), 64'h3);
    edge_upd();
    idle(); fl = 1'b1; issue(4); cyc();
    idle(); rd(0, 4); sample();
    chk("flush_cnt", 64'(cnt_a), 64'h0);
    chk("flush_rvalid", 64'(rvalid_a[0]), 64'h1);
    edge_upd();

    // Reset mid-operation wins over write and issue
    idle(); issue(1); cyc();
    idle(); issue(5); cyc();
    idle(); sample();
    chk("pre_rst_cnt", 64'(cnt_a), 64'h2);
    edge_upd();
    idle(); rst = 1'b1; wr(2, 32'h77); issue(6); cyc();
    idle(); rd(0, 2); rd(1, 1); rd(2, 3); sample();
    chk("mid_rst_x2", 64'(rdata_a[31:0]), 64'h0);
    chk("mid_rst_cnt", 64'(cnt_a), 64'h0);
    chk("mid_rst_rvalid", 64'(rvalid_a), 64'h3);
    chk("mid_rst_x3", 64'(rdata_b[95:64]), 64'h0);
    edge_upd();

    // Three independent read ports
    idle(); wr(10, 32'hA); cyc();
    idle(); wr(11, 32'hB); cyc();
    idle(); wr(12, 32'hC); cyc();
    idle(); rd(0, 10); rd(1, 11); rd(2, 12); sample();
    chk("rd3_p0", 64'(rdata_b[31:0]), 64'hA);
    chk("rd3_p1", 64'(rdata_b[63:32]), 64'hB);
    chk("rd3_p2", 64'(rdata_b[95:64]), 64'hC);
    chk("rd3_rvalid", 64'(rvalid_b), 64'h7);
    edge_upd();

    // Mixed vectors on a small address range to provoke collisions
    for (int n = 0; n < 300; n++) begin
      idle();
      re  = 3'($urandom);
      for (int k = 0; k < 3; k++) ra[k] = AW'($urandom_range(0, 7));
      we  = 1'($urandom);
      wa  = AW'($urandom_range(0, 7));
      wd  = DW'($urandom);
      iss = 1'($urandom);
      ia  = AW'($urandom_range(0, 7));
      fl  = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 63) == 0);
      cyc();
    end

    idle();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
